// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg: shared constants for the ALU writeback stage.
//   PC_IDX           register index that redirects to a PC load
//   FLAG_N/Z/C       bit positions in the packed 3-bit flags bus fed to ALU units
//   WB_DEPTH         default writeback queue depth (2 or 4)
package alu_writeback_pkg;
  localparam int PC_IDX   = 15;
  localparam int FLAG_N   = 2;
  localparam int FLAG_Z   = 1;
  localparam int FLAG_C   = 0;
  localparam int WB_DEPTH = 2;
endpackage

// File: rtl/alu_writeback_fifo.sv
// wb_fifo: in-order DEPTH x {rd, data} writeback queue.
//   clk, rst            clock, synchronous active-low reset
//   i_push/i_rd/i_data  enqueue at tail (caller guarantees not full)
//   i_pop               dequeue head (caller guarantees not empty)
//   o_head_rd/o_head_data  head entry
//   o_count             occupancy
//   o_vld/o_rd          per-entry valid and rd, for the hazard compare
module wb_fifo #(
  parameter int DEPTH  = 2,
  parameter int REG_AW = 4,
  parameter int DATA_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_push,
  input  logic [REG_AW-1:0]                 i_rd,
  input  logic [DATA_W-1:0]                 i_data,
  input  logic                              i_pop,
  output logic [REG_AW-1:0]                 o_head_rd,
  output logic [DATA_W-1:0]                 o_head_data,
  output logic [CW-1:0]                     o_count,
  output logic [DEPTH-1:0]                  o_vld,
  output logic [DEPTH-1:0][REG_AW-1:0]      o_rd
);
  logic [DEPTH-1:0][REG_AW-1:0] r_rd;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [DEPTH-1:0]             r_vld;
  logic [PW-1:0]                r_wptr, r_rptr;
  logic [CW-1:0]                r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Pop clears before push sets; pointers wrap naturally (DEPTH is 2^PW).
      if (i_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      if (i_push) begin
        r_rd[r_wptr]   <= i_rd;
        r_data[r_wptr] <= i_data;
        r_vld[r_wptr]  <= 1'b1;
        r_wptr         <= r_wptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_rd   = r_rd[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_count     = r_count;
  assign o_vld       = r_vld;
  assign o_rd        = r_rd;
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: accepts ALU results, owns the N/Z/C flag register, queues
// register writes and drains them to the register file; R15 writes become a
// one-cycle PC redirect.
//   in_*        ALU result handshake (in_valid/in_ready) and payload
//   rf_*        register-file write port, rf_ack completes a write
//   pc_load/pc_value   PC redirect from a queued R15 write
//   flag_c/z/n  architectural flags
//   hz_addr/hz_pending decode hazard query against queued writes
//   q_count     queue occupancy
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_wr,
  input  logic [REG_AW-1:0]        in_rd,
  input  logic                     in_s,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_c,
  input  logic                     in_z,
  input  logic                     in_n,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic                     rf_ack,
  output logic                     pc_load,
  output logic [DATA_W-1:0]        pc_value,
  output logic                     flag_c,
  output logic                     flag_z,
  output logic                     flag_n,
  input  logic [REG_AW-1:0]        hz_addr,
  output logic                     hz_pending,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]                   r_flags;
  logic [CW-1:0]                w_count;
  logic [REG_AW-1:0]            w_head_rd;
  logic [DATA_W-1:0]            w_head_data;
  logic [DEPTH-1:0]             w_vld;
  logic [DEPTH-1:0][REG_AW-1:0] w_ent_rd;
  logic                         w_full, w_head_vld, w_head_pc;
  logic                         w_accept, w_push, w_pop, w_hz;

  // Full only blocks ops that need a slot; compare ops always pass.
  assign w_full     = (w_count == CW'(DEPTH));
  assign in_ready   = ~w_full | ~in_wr;
  assign w_accept   = in_valid & in_ready;
  assign w_push     = w_accept & in_wr;

  assign w_head_vld = (w_count != '0);
  assign w_head_pc  = w_head_vld & (w_head_rd == REG_AW'(PC_IDX));
  // PC redirects pop unconditionally; RF writes wait for the ack.
  assign w_pop      = (rf_we & rf_ack) | w_head_pc;

  assign rf_we      = w_head_vld & ~w_head_pc;
  assign rf_waddr   = rf_we ? w_head_rd : '0;
  assign rf_wdata   = rf_we ? w_head_data : '0;
  assign pc_load    = w_head_pc;
  assign pc_value   = w_head_pc ? {w_head_data[DATA_W-1:1], 1'b0} : '0;

  wb_fifo #(.DEPTH(DEPTH), .REG_AW(REG_AW), .DATA_W(DATA_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_rd        (in_rd),
    .i_data      (in_result),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_vld       (w_vld),
    .o_rd        (w_ent_rd)
  );

  // Results arrive in order, so flags can commit at accept time.
  always_ff @(posedge clk) begin
    if (!rst)                 r_flags <= '0;
    else if (w_accept & in_s) begin
      r_flags[FLAG_C] <= in_c;
      r_flags[FLAG_Z] <= in_z;
      r_flags[FLAG_N] <= in_n;
    end
  end

  assign flag_c = r_flags[FLAG_C];
  assign flag_z = r_flags[FLAG_Z];
  assign flag_n = r_flags[FLAG_N];

  // Only registered entries count; the result being accepted now is not yet queued.
  always_comb begin
    w_hz = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (w_vld[i] && (w_ent_rd[i] == hz_addr)) w_hz = 1'b1;
  end
  assign hz_pending = w_hz;
  assign q_count    = w_count;
endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  logic        clk = 0, rst = 0;
  logic        in_valid = 0, in_ready, in_wr = 0, in_s = 0, in_c = 0, in_z = 0, in_n = 0;
  logic [3:0]  in_rd = 0, rf_waddr, hz_addr = 0;
  logic [31:0] in_result = 0, rf_wdata, pc_value;
  logic        rf_we, rf_ack, pc_load, flag_c, flag_z, flag_n, hz_pending;
  logic [1:0]  q_count;
  logic        man_ack = 0, pat_mode = 0;
  logic [5:0]  pat = 6'b101101;  // ack sequence 1,0,1,1,0,1 from bit 0
  int          cyc = 0;
  int          n_checks = 0, n_fail = 0, n_drained = 0;
  logic [35:0] wq[$];            // expected {addr, data} register writes
  logic [31:0] pcq[$];           // expected PC redirect values

  assign rf_ack = pat_mode ? pat[cyc % 6] : man_ack;

  alu_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr),
    .in_rd(in_rd), .in_s(in_s), .in_result(in_result), .in_c(in_c), .in_z(in_z),
    .in_n(in_n), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_ack(rf_ack), .pc_load(pc_load), .pc_value(pc_value), .flag_c(flag_c),
    .flag_z(flag_z), .flag_n(flag_n), .hz_addr(hz_addr), .hz_pending(hz_pending),
    .q_count(q_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every completed RF write / PC redirect must match the queue head.
  always @(negedge clk) begin
    if (rst && rf_we && rf_ack) begin
      n_checks++;
      n_drained++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write: unexpected write addr=%0d data=%h", rf_waddr, rf_wdata);
      end else begin
        logic [35:0] e;
        e = wq.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          n_fail++;
          $display("FAIL rf_write: got %0d/%h expected %0d/%h", rf_waddr, rf_wdata, e[35:32], e[31:0]);
        end
      end
    end
    if (rst && pc_load) begin
      n_checks++;
      if (pcq.size() == 0) begin
        n_fail++;
        $display("FAIL pc_load: unexpected redirect to %h", pc_value);
      end else begin
        logic [31:0] p;
        p = pcq.pop_front();
        if (pc_value !== p) begin
          n_fail++;
          $display("FAIL pc_value: got %h expected %h", pc_value, p);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one ALU result, wait (bounded) for acceptance, log expected write.
  task automatic send(input logic wr, input logic [3:0] rd, input logic [31:0] d,
                      input logic s, input logic c, input logic z, input logic n);
    int w = 0;
    in_valid = 1; in_wr = wr; in_rd = rd; in_result = d; in_s = s;
    in_c = c; in_z = z; in_n = n;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else if (wr) begin
      if (rd == 4'd15) pcq.push_back({d[31:1], 1'b0});
      else             wq.push_back({rd, d});
    end
    tick();
    in_valid = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    tick(); tick(); rst = 1;
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_flags", {29'd0, flag_n, flag_z, flag_c}, 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_pc_load", 32'(pc_load), 0);
    in_wr = 1;
    chk("rst_in_ready", 32'(in_ready), 1);
  endtask

  task automatic test_basic();
    man_ack = 1;
    send(1, 3, 32'hA5, 1, 1, 0, 0);
    chk("basic_rf_we", 32'(rf_we), 1);
    chk("basic_waddr", 32'(rf_waddr), 3);
    chk("basic_wdata", rf_wdata, 32'hA5);
    chk("basic_flags", {29'd0, flag_n, flag_z, flag_c}, 32'b001);
    tick();
    chk("basic_drained", 32'(q_count), 0);
  endtask

  task automatic test_full_and_compare();
    man_ack = 0;
    send(1, 1, 32'h11, 0, 0, 0, 0);
    send(1, 2, 32'h22, 0, 0, 0, 0);
    in_wr = 1;
    chk("full_count", 32'(q_count), 2);
    chk("full_ready", 32'(in_ready), 0);
    tick();
    chk("hold_we", 32'(rf_we), 1);
    chk("hold_waddr", 32'(rf_waddr), 1);
    chk("hold_wdata", rf_wdata, 32'h11);
    hz_addr = 2; #1;
    chk("hz_hit", 32'(hz_pending), 1);
    hz_addr = 5; #1;
    chk("hz_miss", 32'(hz_pending), 0);
    send(0, 0, 32'h0, 1, 0, 1, 0);  // compare op while full
    chk("cmp_flags", {29'd0, flag_n, flag_z, flag_c}, 32'b010);
    chk("cmp_count", 32'(q_count), 2);
    man_ack = 1; tick(); tick(); man_ack = 0;
    in_wr = 1;
    chk("drain_count", 32'(q_count), 0);
    chk("drain_ready", 32'(in_ready), 1);
  endtask

  task automatic test_pc_redirect();
    man_ack = 0;
    send(1, 15, 32'h1235, 0, 0, 0, 0);
    chk("pc_load", 32'(pc_load), 1);
    chk("pc_value", pc_value, 32'h1234);
    chk("pc_no_we", 32'(rf_we), 0);
    tick();
    chk("pc_pulse_end", 32'(pc_load), 0);
    chk("pc_popped", 32'(q_count), 0);
  endtask

  task automatic test_back_to_back();
    int w = 0;
    n_drained = 0;
    pat_mode = 1;
    for (int i = 0; i < 6; i++) send(1, 4'(i), 32'h100 + 32'(i), 0, 0, 0, 0);
    while ((q_count != 0) && w < 50) begin tick(); w++; end
    pat_mode = 0;
    chk("stream_empty", 32'(q_count), 0);
    chk("stream_count", 32'(n_drained), 6);
    chk("stream_sb_empty", 32'(wq.size()), 0);
  endtask

  task automatic test_mid_reset();
    man_ack = 0;
    send(0, 0, 32'h0, 1, 1, 0, 1);   // NZC = 101
    send(1, 7, 32'h77, 0, 0, 0, 0);
    send(1, 8, 32'h88, 0, 0, 0, 0);
    chk("pre_rst_count", 32'(q_count), 2);
    chk("pre_rst_flags", {29'd0, flag_n, flag_z, flag_c}, 32'b101);
    rst = 0; tick();
    chk("mid_rst_count", 32'(q_count), 0);
    chk("mid_rst_we", 32'(rf_we), 0);
    chk("mid_rst_flags", {29'd0, flag_n, flag_z, flag_c}, 0);
    wq.delete();
    rst = 1; man_ack = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("post_rst_no_we", 32'(rf_we), 0); end
    man_ack = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_and_compare();
    test_pc_redirect();
    test_back_to_back();
    test_mid_reset();
    chk("final_pc_sb_empty", 32'(pcq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
